s_to_t_arbiter: RTL and testbench

//  Round-robin scheduler sharing one sign-magnitude to two's-complement converter among
//  NUM_REQ message producers (check/variable node units) in the LDPC decoder. Grants at

---
 rtl/s_to_t_arbiter_if.sv | 29 ++
 rtl/s_to_t_arbiter.sv | 83 ++++++++
 tb/tb_s_to_t_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/s_to_t_arbiter_if.sv
// Handshake bundle between the LDPC message producers, the shared
// sign-magnitude to two's-complement converter and its downstream consumer.
interface s_to_t_arbiter_if #(
  parameter int DATA_WIDTH = 6,
  parameter int NUM_REQ    = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          out_valid;
  logic [DATA_WIDTH-1:0]         out_data;
  logic [ID_W-1:0]               out_id;
  logic                          out_ready;
  logic [15:0]                   conv_cnt;

  // Producers and consumer side of the bundle
  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id, conv_cnt
  );

  // Arbiter side of the bundle
  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id, conv_cnt
  );
endinterface

// File: rtl/s_to_t_arbiter.sv
// Round-robin arbiter feeding one shared sign-magnitude to two's-complement
// converter; the converted word sits in a registered output stage tagged
// with the index of the requester that produced it.
module s_to_t_arbiter #(
  parameter int DATA_WIDTH = 6,
  parameter int NUM_REQ    = 4
) (
  input logic              clk,
  input logic              rst_n,
  s_to_t_arbiter_if.slave  bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ID_W-1:0]       ptr;
  logic [ID_W-1:0]       cand;
  logic [ID_W-1:0]       grantIdx;
  logic                  found;
  logic                  canTake;
  logic                  grantValid;
  logic [NUM_REQ-1:0]    grant;
  logic [DATA_WIDTH-1:0] selWord;

  // Negative words become the two's complement of their magnitude; a
  // negative zero therefore collapses to zero.
  function automatic logic [DATA_WIDTH-1:0] conv(input logic [DATA_WIDTH-1:0] w);
    if (w[DATA_WIDTH-1])
      return -{1'b0, w[DATA_WIDTH-2:0]};
    else
      return w;
  endfunction

  // Search requesters starting at the round-robin pointer and pick the first valid one
  always_comb begin
    found    = 1'b0;
    grantIdx = '0;
    cand     = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      cand = ID_W'((int'(ptr) + j) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found    = 1'b1;
        grantIdx = cand;
      end
    end
  end

  // Grant only when the output stage is empty or being drained this cycle
  always_comb begin
    canTake    = !bus.out_valid || bus.out_ready;
    grantValid = rst_n && canTake && found;
    grant      = '0;
    if (grantValid)
      grant[grantIdx] = 1'b1;
    bus.req_ready = grant;
  end

  // Route the granted requester's word to the converter
  always_comb begin
    selWord = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (ID_W'(j) == grantIdx)
        selWord = bus.req_data[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Output stage, pointer advance and conversion counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_id    <= '0;
      bus.conv_cnt  <= '0;
      ptr           <= '0;
    end else if (grantValid) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= conv(selWord);
      bus.out_id    <= grantIdx;
      bus.conv_cnt  <= bus.conv_cnt + 16'd1;
      ptr           <= (grantIdx == ID_W'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_s_to_t_arbiter.sv
// Directed self-checking bench for the round-robin sign-magnitude converter.
module tb_s_to_t_arbiter;
  localparam int DW = 6;
  localparam int NR = 4;

  logic clk;
  logic rst_n;
  int   assertCount;
  int   failCount;

  s_to_t_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  s_to_t_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the directed sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [NR*DW-1:0] pack(input logic [DW-1:0] d0, d1, d2, d3);
    return {d3, d2, d1, d0};
  endfunction

  // Reference conversion written as modular arithmetic: -m mod 2^W
  function automatic logic [DW-1:0] refConv(input int v);
    int mag;
    if (v < 32) return DW'(v);
    mag = v - 32;
    return DW'((64 - mag) % 64);
  endfunction

  task automatic applyStimulus(input logic [NR-1:0] valid, input logic [NR*DW-1:0] data,
                               input logic outReady);
    bus.req_valid = valid;
    bus.req_data  = data;
    bus.out_ready = outReady;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkStage(input string tag, input logic v, input logic [DW-1:0] d,
                            input int id, input int cnt);
    checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
    checkOutput({tag, "_data"},  32'(bus.out_data),  32'(d));
    checkOutput({tag, "_id"},    32'(bus.out_id),    32'(id));
    checkOutput({tag, "_cnt"},   32'(bus.conv_cnt),  32'(cnt));
  endtask

  logic [DW-1:0] expData [NR];
  logic [DW-1:0] sweepWord;

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;

    // Reset state, with requests pending to show req_ready is gated
    #11;
    applyStimulus(4'b1111, '0, 1'b1);
    checkStage("reset", 1'b0, 6'd0, 0, 0);
    checkOutput("reset_ready", 32'(bus.req_ready), 32'h0);
    applyStimulus(4'b0000, '0, 1'b0);
    rst_n = 1'b1;
    tick();

    $display("[TB] single request on req0");
    applyStimulus(4'b0001, pack(6'b000111, 6'd0, 6'd0, 6'd0), 1'b1);
    checkOutput("t1_ready", 32'(bus.req_ready), 32'b0001);
    tick();
    checkStage("t1", 1'b1, 6'b000111, 0, 1);
    applyStimulus(4'b0000, '0, 1'b1);
    checkOutput("t1_idle_ready", 32'(bus.req_ready), 32'h0);
    tick();
    checkOutput("t1_drain_valid", 32'(bus.out_valid), 32'h0);

    $display("[TB] directed conversions on req2");
    applyStimulus(4'b0100, pack(6'd0, 6'd0, 6'b100101, 6'd0), 1'b1);
    tick();
    checkStage("t2_neg5", 1'b1, 6'b111011, 2, 2);
    applyStimulus(4'b0100, pack(6'd0, 6'd0, 6'b111111, 6'd0), 1'b1);
    tick();
    checkStage("t2_neg31", 1'b1, 6'b100001, 2, 3);
    applyStimulus(4'b0100, pack(6'd0, 6'd0, 6'b100000, 6'd0), 1'b1);
    tick();
    checkStage("t2_negzero", 1'b1, 6'b000000, 2, 4);

    $display("[TB] full sweep on req2");
    for (int v = 0; v < 64; v++) begin
      sweepWord = DW'(v);
      applyStimulus(4'b0100, pack(6'd0, 6'd0, sweepWord, 6'd0), 1'b1);
      tick();
      checkOutput($sformatf("t2_sweep_data_%0d", v), 32'(bus.out_data), 32'(refConv(v)));
      checkOutput($sformatf("t2_sweep_id_%0d", v), 32'(bus.out_id), 32'd2);
    end
    checkOutput("t2_cnt", 32'(bus.conv_cnt), 32'd68);

    // Grant req3 alone so the pointer wraps back to 0
    applyStimulus(4'b1000, pack(6'd0, 6'd0, 6'd0, 6'b000100), 1'b1);
    tick();
    checkStage("t3_pre", 1'b1, 6'b000100, 3, 69);

    $display("[TB] all requesters valid, round-robin order");
    expData[0] = 6'b000001;
    expData[1] = 6'b000010;
    expData[2] = 6'b111101;
    expData[3] = 6'b000100;
    for (int n = 0; n < 6; n++) begin
      applyStimulus(4'b1111, pack(6'b000001, 6'b000010, 6'b100011, 6'b000100), 1'b1);
      checkOutput($sformatf("t3_ready_%0d", n), 32'(bus.req_ready), 32'(1 << (n % 4)));
      tick();
      checkStage($sformatf("t3_out_%0d", n), 1'b1, expData[n % 4], n % 4, 70 + n);
    end

    $display("[TB] back-pressure holds the output stage");
    for (int n = 0; n < 5; n++) begin
      applyStimulus(4'b1111, pack(6'b000001, 6'b000010, 6'b100011, 6'b000100), 1'b0);
      checkOutput($sformatf("t4_ready_%0d", n), 32'(bus.req_ready), 32'h0);
      tick();
      checkStage($sformatf("t4_hold_%0d", n), 1'b1, 6'b000010, 1, 75);
    end
    applyStimulus(4'b1111, pack(6'b000001, 6'b000010, 6'b100011, 6'b000100), 1'b1);
    checkOutput("t4_release_ready", 32'(bus.req_ready), 32'b0100);
    tick();
    checkStage("t4_release", 1'b1, 6'b111101, 2, 76);

    // Grant req1 alone so the pointer sits at 2
    applyStimulus(4'b0010, pack(6'd0, 6'b000010, 6'd0, 6'd0), 1'b1);
    tick();
    checkStage("t5_pre", 1'b1, 6'b000010, 1, 77);

    $display("[TB] sparse requesters 1 and 3");
    applyStimulus(4'b1010, pack(6'd0, 6'b000010, 6'd0, 6'b000100), 1'b1);
    checkOutput("t5_ready_a", 32'(bus.req_ready), 32'b1000);
    tick();
    checkStage("t5_a", 1'b1, 6'b000100, 3, 78);
    checkOutput("t5_ready_b", 32'(bus.req_ready), 32'b0010);
    tick();
    checkStage("t5_b", 1'b1, 6'b000010, 1, 79);
    checkOutput("t5_ready_c", 32'(bus.req_ready), 32'b1000);
    tick();
    checkStage("t5_c", 1'b1, 6'b000100, 3, 80);

    $display("[TB] asynchronous reset mid-stream");
    applyStimulus(4'b1010, pack(6'd0, 6'b000010, 6'd0, 6'b000100), 1'b0);
    tick();
    checkStage("t6_pre", 1'b1, 6'b000100, 3, 80);
    #2;
    rst_n = 1'b0;
    #1;
    checkStage("t6_reset", 1'b0, 6'd0, 0, 0);
    checkOutput("t6_reset_ready", 32'(bus.req_ready), 32'h0);
    #1;
    rst_n = 1'b1;
    applyStimulus(4'b1010, pack(6'd0, 6'b000010, 6'd0, 6'b000100), 1'b1);
    checkOutput("t6_first_ready", 32'(bus.req_ready), 32'b0010);
    tick();
    checkStage("t6_first", 1'b1, 6'b000010, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
